// File: rtl/otter_fetch_stage.sv
// OTTER RV32I instruction-fetch stage: owns the fetch PC, drives the synchronous
// instruction memory port and presents the IF/ID slot with stall skid and EX redirect.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          IMEM_AW   = 14
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic [31:0]        REDIRECT_PC,
  output logic               IMEM_RDEN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_DOUT,
  output logic [31:0]        IF_ID_PC,
  output logic [31:0]        IF_ID_PC_INC,
  output logic [31:0]        IF_ID_IR,
  output logic               IF_ID_VALID
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic [31:0] pc_dec_q,   pc_dec_d;
  logic [31:0] hold_ir_q,  hold_ir_d;
  logic        hold_vld_q, hold_vld_d;
  logic        slot_vld_q, slot_vld_d;

  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // Next-state: FLUSH outranks STALL, STALL outranks advance.
  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch_q;
    pc_dec_d   = pc_dec_q;
    hold_ir_d  = hold_ir_q;
    hold_vld_d = hold_vld_q;
    slot_vld_d = slot_vld_q;
    if (FLUSH) begin
      pc_fetch_d = {REDIRECT_PC[31:2], 2'b00};
      slot_vld_d = 1'b0;
      hold_vld_d = 1'b0;
      state_d    = RUN;
    end else if (STALL) begin
      // Only the first stalled cycle of a live slot has a word worth keeping;
      // the memory is not read again until the stall lifts.
      if (state_q == RUN && slot_vld_q) begin
        hold_ir_d  = IMEM_DOUT;
        hold_vld_d = 1'b1;
        state_d    = HOLD;
      end
    end else begin
      pc_dec_d   = pc_fetch_q;
      pc_fetch_d = pc_fetch_q + 32'd4;
      slot_vld_d = 1'b1;
      hold_vld_d = 1'b0;
      state_d    = RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= BOOT;
      pc_fetch_q <= RESET_VEC;
      pc_dec_q   <= RESET_VEC;
      hold_vld_q <= 1'b0;
      slot_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_fetch_q <= pc_fetch_d;
      pc_dec_q   <= pc_dec_d;
      hold_vld_q <= hold_vld_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  // Skid data is qualified by hold_vld_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    hold_ir_q <= hold_ir_d;
  end

  assign IMEM_ADDR    = pc_fetch_q[IMEM_AW+1:2];
  assign IMEM_RDEN    = ~RST & (FLUSH | ~STALL);
  assign IF_ID_PC     = pc_dec_q;
  assign IF_ID_PC_INC = pc_dec_q + 32'd4;
  assign IF_ID_IR     = hold_vld_q ? hold_ir_q : IMEM_DOUT;
  assign IF_ID_VALID  = (state_q != BOOT) & slot_vld_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: directed vector table, hand sequences for reset and
// wrap corners, and randomized stall/flush traffic against a slot-level reference model.
module tb_otter_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [31:0] redir;
  logic        rden;
  logic [13:0] addr;
  logic [31:0] dout, pc, pc_inc, ir;
  logic        valid;

  logic        rst6, stall6, flush6;
  logic [31:0] redir6;
  logic        rden6;
  logic [13:0] addr6;
  logic [31:0] dout6, pc6, pc_inc6, ir6;
  logic        valid6;

  int nvec = 0;
  int nmis = 0;

  otter_fetch_stage #(.RESET_VEC(32'h0000_0000), .IMEM_AW(14)) dut (
    .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush), .REDIRECT_PC(redir),
    .IMEM_RDEN(rden), .IMEM_ADDR(addr), .IMEM_DOUT(dout),
    .IF_ID_PC(pc), .IF_ID_PC_INC(pc_inc), .IF_ID_IR(ir), .IF_ID_VALID(valid)
  );

  otter_fetch_stage #(.RESET_VEC(32'hFFFF_FFF8), .IMEM_AW(14)) dut6 (
    .CLK(clk), .RST(rst6), .STALL(stall6), .FLUSH(flush6), .REDIRECT_PC(redir6),
    .IMEM_RDEN(rden6), .IMEM_ADDR(addr6), .IMEM_DOUT(dout6),
    .IF_ID_PC(pc6), .IF_ID_PC_INC(pc_inc6), .IF_ID_IR(ir6), .IF_ID_VALID(valid6)
  );

  function automatic logic [31:0] word(input logic [13:0] a);
    return 32'h0000_0013 + ({18'b0, a} << 20);
  endfunction

  // Memory: sync read; output is junk on cycles without a read.
  always @(posedge clk) begin
    if (rden) dout <= word(addr);
    else      dout <= $urandom;
    if (rden6) dout6 <= word(addr6);
    else       dout6 <= $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the slot holds (pc, word(pc)) of the last instruction handed to
  // decode; m_next is the address the next advance will deliver.
  logic [31:0] m_next, m_slot_pc;
  bit          m_slot_vld;

  task automatic model_reset();
    m_next     = 32'h0;
    m_slot_pc  = 32'h0;
    m_slot_vld = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit f, input logic [31:0] r);
    if (f) begin
      m_next     = {r[31:2], 2'b00};
      m_slot_vld = 1'b0;
    end else if (!s) begin
      m_slot_pc  = m_next;
      m_next     = m_next + 32'd4;
      m_slot_vld = 1'b1;
    end
  endtask

  task automatic model_chk(input bit s, input bit f);
    chk("valid",  {31'b0, valid}, {31'b0, m_slot_vld});
    chk("pc",     pc,     m_slot_pc);
    chk("pc_inc", pc_inc, m_slot_pc + 32'd4);
    chk("addr",   {18'b0, addr}, {18'b0, m_next[15:2]});
    chk("rden",   {31'b0, rden}, {31'b0, (f | ~s)});
    if (m_slot_vld) chk("ir", ir, word(m_slot_pc[15:2]));
  endtask

  task automatic step(input bit s, input bit f, input logic [31:0] r);
    @(negedge clk);
    stall = s; flush = f; redir = r;
    #1;
    model_chk(s, f);
    @(posedge clk);
    model_edge(s, f, r);
  endtask

  // Asserts reset mid-cycle (whatever STALL/FLUSH are doing) and releases it
  // just after a rising edge so the next step sees the first post-reset cycle.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid",  {31'b0, valid}, 32'd0);
    chk("rst_rden",   {31'b0, rden},  32'd0);
    chk("rst_addr",   {18'b0, addr},  32'd0);
    chk("rst_pc",     pc,     32'h0);
    chk("rst_pc_inc", pc_inc, 32'h4);
    stall = 1'b0; flush = 1'b0; redir = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  typedef struct {
    bit          stall;
    bit          flush;
    logic [31:0] redir;
    bit          valid;
    logic [31:0] pc;
    logic [13:0] addr;
    bit          rden;
  } vec_t;

  vec_t tbl[17];

  task automatic set_v(input int i, input bit s, input bit f, input logic [31:0] r,
                       input bit v, input logic [31:0] p, input logic [13:0] a, input bit rd);
    tbl[i].stall = s; tbl[i].flush = f; tbl[i].redir = r;
    tbl[i].valid = v; tbl[i].pc = p; tbl[i].addr = a; tbl[i].rden = rd;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redir = 32'h0;
    rst6 = 1'b1; stall6 = 1'b0; flush6 = 1'b0; redir6 = 32'h0;

    // Boot stream, 3-cycle stall at PC 8, flush to 0x103, flush+stall to 0x20
    // followed by a stall during the bubble.
    set_v( 0, 0, 0, 32'h0,   0, 32'h000, 14'h000, 1);
    set_v( 1, 0, 0, 32'h0,   1, 32'h000, 14'h001, 1);
    set_v( 2, 0, 0, 32'h0,   1, 32'h004, 14'h002, 1);
    set_v( 3, 1, 0, 32'h0,   1, 32'h008, 14'h003, 0);
    set_v( 4, 1, 0, 32'h0,   1, 32'h008, 14'h003, 0);
    set_v( 5, 1, 0, 32'h0,   1, 32'h008, 14'h003, 0);
    set_v( 6, 0, 0, 32'h0,   1, 32'h008, 14'h003, 1);
    set_v( 7, 0, 0, 32'h0,   1, 32'h00C, 14'h004, 1);
    set_v( 8, 0, 1, 32'h103, 1, 32'h010, 14'h005, 1);
    set_v( 9, 0, 0, 32'h0,   0, 32'h010, 14'h040, 1);
    set_v(10, 0, 0, 32'h0,   1, 32'h100, 14'h041, 1);
    set_v(11, 1, 1, 32'h20,  1, 32'h104, 14'h042, 1);
    set_v(12, 1, 0, 32'h0,   0, 32'h104, 14'h008, 0);
    set_v(13, 1, 0, 32'h0,   0, 32'h104, 14'h008, 0);
    set_v(14, 0, 0, 32'h0,   0, 32'h104, 14'h008, 1);
    set_v(15, 0, 0, 32'h0,   1, 32'h020, 14'h009, 1);
    set_v(16, 0, 0, 32'h0,   1, 32'h024, 14'h00A, 1);

    do_reset();

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      stall = tbl[i].stall; flush = tbl[i].flush; redir = tbl[i].redir;
      #1;
      chk($sformatf("t%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].valid});
      chk($sformatf("t%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("t%0d_pc_inc", i), pc_inc, tbl[i].pc + 32'd4);
      chk($sformatf("t%0d_addr", i), {18'b0, addr}, {18'b0, tbl[i].addr});
      chk($sformatf("t%0d_rden", i), {31'b0, rden}, {31'b0, tbl[i].rden});
      if (tbl[i].valid) chk($sformatf("t%0d_ir", i), ir, word(tbl[i].pc[15:2]));
      @(posedge clk);
      model_edge(tbl[i].stall, tbl[i].flush, tbl[i].redir);
    end

    // Reach PC 0x40, stall into HOLD, then reset while still stalled.
    step(0, 1, 32'h40);
    step(0, 0, 32'h0);
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    chk("hold_pc", pc, 32'h40);
    do_reset();
    step(0, 0, 32'h0);
    chk("rst_restart_pc0", pc, 32'h0);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    chk("rst_restart_pc4", pc, 32'h4);
    step(0, 0, 32'h0);

    // Randomized traffic, with an occasional reset thrown in.
    for (int n = 0; n < 1500; n++) begin
      bit          s, f;
      logic [31:0] r;
      if ($urandom_range(0, 299) == 0) do_reset();
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      step(s, f, r);
    end

    // Wrap-around from RESET_VEC = FFFF_FFF8 on the second instance.
    @(negedge clk);
    #1;
    chk("w_rst_valid",  {31'b0, valid6}, 32'd0);
    chk("w_rst_rden",   {31'b0, rden6},  32'd0);
    chk("w_rst_addr",   {18'b0, addr6},  32'h3FFE);
    chk("w_rst_pc",     pc6,     32'hFFFF_FFF8);
    chk("w_rst_pc_inc", pc_inc6, 32'hFFFF_FFFC);
    @(posedge clk);
    #2 rst6 = 1'b0;
    @(negedge clk); #1;
    chk("w0_valid", {31'b0, valid6}, 32'd0);
    @(negedge clk); #1;
    chk("w1_valid",  {31'b0, valid6}, 32'd1);
    chk("w1_pc",     pc6,     32'hFFFF_FFF8);
    chk("w1_ir",     ir6,     word(14'h3FFE));
    @(negedge clk); #1;
    chk("w2_pc",     pc6,     32'hFFFF_FFFC);
    chk("w2_pc_inc", pc_inc6, 32'h0000_0000);
    chk("w2_ir",     ir6,     word(14'h3FFF));
    @(negedge clk); #1;
    chk("w3_pc",     pc6,     32'h0000_0000);
    chk("w3_pc_inc", pc_inc6, 32'h0000_0004);
    chk("w3_ir",     ir6,     word(14'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
